// File: rtl/btn_press_if.sv
// Button decoder signal bundle: debounced level in, press events and held status out.
// The slave modport is the decoder side; the master modport is the consumer/driver side.
interface btn_press_if;
  logic btn_level_i;
  logic short_press_o;
  logic long_press_o;
  logic repeat_o;
  logic held_o;

  modport slave (
    input  btn_level_i,
    output short_press_o,
    output long_press_o,
    output repeat_o,
    output held_o
  );

  modport master (
    output btn_level_i,
    input  short_press_o,
    input  long_press_o,
    input  repeat_o,
    input  held_o
  );
endinterface

// File: rtl/btn_press_decoder.sv
// Classifies debounced button presses into short/long pulses and a held level.
// Define BTN_AUTOREPEAT_EN to add periodic repeat pulses while a long press is held.
//
// state     | meaning
// IDLE      | waiting for an armed press
// PRESSED   | button down, counting toward the long threshold
// LONG_HELD | long press reported, waiting for release (auto-repeat if enabled)
module btn_press_decoder #(
  parameter int LONG_CLOCKS   = 50_000_000,
  parameter int REPEAT_CLOCKS = 10_000_000
) (
  input logic       clk,
  input logic       rst,
  btn_press_if.slave bus
);

  localparam int CNT_MAX = (LONG_CLOCKS > REPEAT_CLOCKS) ? LONG_CLOCKS : REPEAT_CLOCKS;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CLOCKS - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CLOCKS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          armed_q;
  logic          short_q;
  logic          long_q;
  logic          held_q;
`ifdef BTN_AUTOREPEAT_EN
  logic          repeat_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
      // A level already high out of reset must be released once before it counts.
      if (!bus.btn_level_i) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (armed_q && bus.btn_level_i) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            held_q  <= 1'b1;
          end
        end
        PRESSED: begin
          if (!bus.btn_level_i) begin
            short_q <= 1'b1;
            state_q <= IDLE;
            held_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_LAST) begin
            long_q  <= 1'b1;
            state_q <= LONG_HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LONG_HELD: begin
          if (!bus.btn_level_i) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            cnt_q   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (cnt_q == REP_LAST) begin
            repeat_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        default: begin
          state_q <= IDLE;
          held_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.short_press_o = short_q;
  assign bus.long_press_o  = long_q;
  assign bus.held_o        = held_q;
`ifdef BTN_AUTOREPEAT_EN
  assign bus.repeat_o      = repeat_q;
`else
  assign bus.repeat_o      = 1'b0;
`endif

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed bench for btn_press_decoder with LONG_CLOCKS=8, REPEAT_CLOCKS=4.
// Cycle k relative to the first sampled press; outputs are checked mid-cycle.
module tb_btn_press_decoder;
  localparam int LC = 8;
  localparam int RC = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam int R1 = 13;
  localparam int R2 = 17;
`else
  localparam int R1 = -1;
  localparam int R2 = -1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  btn_press_if bus ();

  btn_press_decoder #(.LONG_CLOCKS(LC), .REPEAT_CLOCKS(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic es, input logic el, input logic er, input logic eh);
    chk({tag, ".short"},  bus.short_press_o, es);
    chk({tag, ".long"},   bus.long_press_o,  el);
    chk({tag, ".repeat"}, bus.repeat_o,      er);
    chk({tag, ".held"},   bus.held_o,        eh);
  endtask

  // Drive btn=b for n cycles, expecting all outputs quiet.
  task automatic quiet(input string tag, input int n, input logic b);
    for (int k = 0; k < n; k++) begin
      bus.btn_level_i = b;
      rst = 1'b0;
      @(negedge clk);
      chk_all($sformatf("%s[%0d]", tag, k), 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  // btn=1 for k<hold, rst pulsed at k==rst_at; expected pulse cycles and held window given.
  task automatic press(input string tag, input int hold, input int total, input int rst_at,
                       input int e_short, input int e_long, input int h_lo, input int h_hi,
                       input int r1, input int r2);
    for (int k = 0; k < total; k++) begin
      bus.btn_level_i = (k < hold);
      rst = (k == rst_at);
      @(negedge clk);
      chk_all($sformatf("%s[%0d]", tag, k), (k == e_short), (k == e_long),
              (k == r1) || (k == r2), (k >= h_lo) && (k <= h_hi));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.btn_level_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_all($sformatf("reset[%0d]", k), 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end

    // Button held through reset release: must not register as a press.
    quiet("powerup_held", 30, 1'b1);
    quiet("arm", 1, 1'b0);
    press("short_after_powerup", 3, 6, -1, 4, -1, 1, 3, -1, -1);

    press("short3",        3,  6, -1, 4, -1, 1, 3, -1, -1);
    press("boundary_short", 8, 11, -1, 9, -1, 1, 8, -1, -1);
    press("boundary_long",  9, 12, -1, -1, 9, 1, 9, -1, -1);
    press("long20",        20, 23, -1, -1, 9, 1, 20, R1, R2);

    // Reset while in LONG_HELD with the button still down, then stay pressed.
    press("rst_mid", 26, 26, 12, -1, 9, 1, 12, -1, -1);
    quiet("rearm", 1, 1'b0);
    press("short_after_rst", 3, 6, -1, 4, -1, 1, 3, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/btn_press_decoder.md
Name: btn_press_decoder

Overview:
- Sits directly downstream of the button debouncer and consumes its debounced level output.
- Classifies each press as short or long and emits single-cycle event pulses for the control logic (mode select, counters, menu stepping).
- Provides a held-status level.
- Optionally provides auto-repeat pulses while a long press is held.

Parameters:
- LONG_CLOCKS, 50_000_000, number of held cycles that qualifies a press as long (must be >= 2).
- REPEAT_CLOCKS, 10_000_000, auto-repeat period in cycles once long-held (must be >= 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_level_i  input  1  debounced button level, 1 = pressed.
- short_press_o  output  1  one-cycle pulse: press released before the long threshold.
- long_press_o  output  1  one-cycle pulse: long threshold reached while still pressed.
- repeat_o  output  1  one-cycle auto-repeat pulse (optional feature).
- held_o  output  1  level: 1 while the FSM is outside IDLE.

Behaviour:
- Single clock domain, synchronous active-high reset.
- All outputs are registered; reset value of every output is 0.
- Internal state: FSM {IDLE, PRESSED, LONG_HELD}; counter cnt, width $clog2(max(LONG_CLOCKS, REPEAT_CLOCKS)); armed flag.
- Reset: state = IDLE, cnt = 0, armed = 0, all outputs 0 on the next edge. This applies in any state, mid-press included.
- armed: set on any cycle where btn_level_i = 0.
  - This rule prevents a phantom press when the button is already high out of reset.
- IDLE, armed = 1, btn_level_i = 1 at cycle T: next edge goes to PRESSED with cnt = 0; held_o = 1 from cycle T+1.
- IDLE with armed = 0: btn_level_i is ignored.
- PRESSED, btn_level_i = 0: next edge emits short_press_o = 1 for one cycle and returns to IDLE; held_o = 0.
- PRESSED, btn_level_i = 1, cnt != LONG_CLOCKS-1: cnt increments by 1.
- PRESSED, btn_level_i = 1, cnt == LONG_CLOCKS-1: next edge emits long_press_o = 1 for one cycle, goes to LONG_HELD, cnt = 0.
  - Latency: a press first seen at cycle T gives long_press_o at cycle T+LONG_CLOCKS+1.
- Simultaneous case, release in the same cycle that cnt == LONG_CLOCKS-1: release wins, so short_press_o fires and long_press_o does not.
- LONG_HELD, btn_level_i = 0: next edge returns to IDLE with no pulse. Release after a long press never produces short_press_o.
- LONG_HELD, btn_level_i = 1: counting is as defined by the optional feature.
- Pulse exclusivity: short_press_o, long_press_o and repeat_o are mutually exclusive, and each is high for exactly one cycle.
- cnt never wraps: it is always cleared on the compare match or on a state change.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD with btn_level_i = 1, cnt increments each cycle.
  - When cnt == REPEAT_CLOCKS-1, the next edge emits repeat_o = 1 for one cycle and sets cnt = 0.
  - First repeat_o comes REPEAT_CLOCKS cycles after long_press_o; the period is REPEAT_CLOCKS thereafter.
  - Release on the compare cycle gives no repeat_o.
- Undefined:
  - repeat_o is constant 0.
  - cnt holds at 0 in LONG_HELD.
  - No repeat logic is synthesized.

Test Plan (LONG_CLOCKS=8, REPEAT_CLOCKS=4; press first seen at cycle T):
- Short press: btn=1 for cycles T..T+2, 0 from T+3 -> short_press_o at T+4 only; long_press_o = 0; held_o high T+1..T+3.
- Threshold boundary: btn=1 T..T+7, 0 at T+8 -> short_press_o at T+9. Separately, btn=1 T..T+8 -> long_press_o at T+9 and no short on release.
- Long press without the macro: btn=1 T..T+19 -> long_press_o at T+9; repeat_o = 0 throughout; held_o falls at T+21; no short_press_o.
- Long press with BTN_AUTOREPEAT_EN: btn=1 T..T+19 -> long_press_o at T+9; repeat_o at T+13 and T+17 only.
- Power-up held: btn=1 during and after rst deassert for 30 cycles -> no pulses, held_o = 0. Then btn=0 for 1 cycle and a new 3-cycle press -> normal short_press_o.
- Reset mid-operation: rst=1 at T+12 while in LONG_HELD -> all outputs 0 at T+13. After rst deasserts with btn still 1: no pulse until a release and re-press.
